// File: rtl/alu_result_if.sv
// alu_result_if: ALU-to-writeback beat stream plus the architectural flag output.
// master drives the ALU side and consumes writeback; slave is the result stage.
interface alu_result_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_result;
   logic [3:0]  in_nzcv;
   logic [3:0]  in_rd;
   logic        in_regwrite;
   logic        in_flagwrite;
   logic [3:0]  in_cond;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [3:0]  out_rd;
   logic        out_regwrite;
   logic        out_condfail;
   logic [3:0]  flags_nzcv;
   modport master (
      output in_valid, in_result, in_nzcv, in_rd, in_regwrite, in_flagwrite, in_cond, out_ready,
      input  in_ready, out_valid, out_result, out_rd, out_regwrite, out_condfail, flags_nzcv
   );
   modport slave (
      input  in_valid, in_result, in_nzcv, in_rd, in_regwrite, in_flagwrite, in_cond, out_ready,
      output in_ready, out_valid, out_result, out_rd, out_regwrite, out_condfail, flags_nzcv
   );
endinterface

// File: rtl/alu_result_stage.sv
// alu_result_stage: 2-entry in-order writeback FIFO with condition evaluation and flag register.
// Conditional execution is enabled by defining ALU_RESULT_COND_EXEC_EN.
module alu_result_stage (
   input logic clk,
   input logic rst,
   alu_result_if.slave bus
);
   logic [37:0] mem [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;
   logic [3:0]  flags;
   logic        cond_pass;
   logic        accept;
   logic        pop;
`ifdef ALU_RESULT_COND_EXEC_EN
   logic n, z, c, v;
   assign {n, z, c, v} = flags;
   always_comb begin
      cond_pass = 1'b1;
      case (bus.in_cond)
         4'h0: cond_pass = z;
         4'h1: cond_pass = !z;
         4'h2: cond_pass = c;
         4'h3: cond_pass = !c;
         4'h4: cond_pass = n;
         4'h5: cond_pass = !n;
         4'h6: cond_pass = v;
         4'h7: cond_pass = !v;
         4'h8: cond_pass = c & !z;
         4'h9: cond_pass = !c | z;
         4'hA: cond_pass = n == v;
         4'hB: cond_pass = n != v;
         4'hC: cond_pass = !z & (n == v);
         4'hD: cond_pass = z | (n != v);
         default: cond_pass = 1'b1;
      endcase
   end
`else
   assign cond_pass = 1'b1;
`endif
   // in_ready depends on occupancy only, so no out_ready -> in_ready path exists
   assign bus.in_ready   = count != 2'd2;
   assign bus.out_valid  = count != 2'd0;
   assign bus.flags_nzcv = flags;
   assign accept = bus.in_valid & bus.in_ready;
   assign pop    = bus.out_valid & bus.out_ready;
   assign {bus.out_result, bus.out_rd, bus.out_regwrite, bus.out_condfail} = mem[rd_ptr];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
         flags  <= '0;
      end else begin
         if (accept) mem[wr_ptr] <= {bus.in_result, bus.in_rd, bus.in_regwrite & cond_pass, !cond_pass};
         if (accept) wr_ptr <= ~wr_ptr;
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, accept} - {1'b0, pop};
         if (accept & bus.in_flagwrite & cond_pass) flags <= bus.in_nzcv;
      end
   end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: table-driven condition checks plus scoreboarded FIFO sequences.
// Expectations follow the build: ALU_RESULT_COND_EXEC_EN selects conditional execution.
module tb_alu_result_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   alu_result_if bus ();
   alu_result_stage dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   typedef struct {logic [31:0] r; logic [3:0] d; logic rw; logic cf;} exp_t;
   typedef struct {logic [3:0] cond; logic [3:0] nz; logic pass;} vec_t;
   exp_t q[$];
   vec_t tbl[24];
   logic [3:0] mflags = '0;
   logic cur_pass = 1'b1;
   int checks = 0;
   int failures = 0;

   function automatic logic eff(input logic p);
`ifdef ALU_RESULT_COND_EXEC_EN
      return p;
`else
      return 1'b1;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Called in the negedge phase with inputs already driven; models the next rising edge.
   task automatic tick();
      logic acc, pp;
      exp_t e;
      acc = bus.in_valid && q.size() < 2;
      pp  = q.size() > 0 && bus.out_ready;
      chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
      chk("flags_nzcv", 32'(bus.flags_nzcv), 32'(mflags));
      if (q.size() > 0) begin
         chk("out_result", bus.out_result, q[0].r);
         chk("out_rd", 32'(bus.out_rd), 32'(q[0].d));
         chk("out_regwrite", 32'(bus.out_regwrite), 32'(q[0].rw));
         chk("out_condfail", 32'(bus.out_condfail), 32'(q[0].cf));
      end
      if (pp) e = q.pop_front();
      if (acc) begin
         q.push_back('{bus.in_result, bus.in_rd, bus.in_regwrite & cur_pass, !cur_pass});
         if (bus.in_flagwrite && cur_pass) mflags = bus.in_nzcv;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic [31:0] r, input logic [3:0] d, input logic rw, input logic fw,
                        input logic [3:0] nz, input logic [3:0] c, input logic p);
      bus.in_valid = 1'b1;
      bus.in_result = r;
      bus.in_rd = d;
      bus.in_regwrite = rw;
      bus.in_flagwrite = fw;
      bus.in_nzcv = nz;
      bus.in_cond = c;
      cur_pass = eff(p);
   endtask

   task automatic beat(input logic [31:0] r, input logic [3:0] d, input logic rw, input logic fw,
                       input logic [3:0] nz, input logic [3:0] c, input logic p);
      drive(r, d, rw, fw, nz, c, p);
      tick();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{4'h0, 4'b0100, 1'b1};
      tbl[1]  = '{4'h0, 4'b0000, 1'b0};
      tbl[2]  = '{4'h1, 4'b0000, 1'b1};
      tbl[3]  = '{4'h2, 4'b0010, 1'b1};
      tbl[4]  = '{4'h3, 4'b0010, 1'b0};
      tbl[5]  = '{4'h4, 4'b1000, 1'b1};
      tbl[6]  = '{4'h5, 4'b1000, 1'b0};
      tbl[7]  = '{4'h6, 4'b0001, 1'b1};
      tbl[8]  = '{4'h7, 4'b0000, 1'b1};
      tbl[9]  = '{4'h8, 4'b0010, 1'b1};
      tbl[10] = '{4'h8, 4'b0110, 1'b0};
      tbl[11] = '{4'h9, 4'b0000, 1'b1};
      tbl[12] = '{4'h9, 4'b0010, 1'b0};
      tbl[13] = '{4'hA, 4'b1001, 1'b1};
      tbl[14] = '{4'hA, 4'b1000, 1'b0};
      tbl[15] = '{4'hB, 4'b1000, 1'b1};
      tbl[16] = '{4'hC, 4'b0000, 1'b1};
      tbl[17] = '{4'hC, 4'b1000, 1'b0};
      tbl[18] = '{4'hD, 4'b0100, 1'b1};
      tbl[19] = '{4'hD, 4'b0000, 1'b0};
      tbl[20] = '{4'hE, 4'b0000, 1'b1};
      tbl[21] = '{4'hF, 4'b0000, 1'b1};
      tbl[22] = '{4'h6, 4'b0000, 1'b0};
      tbl[23] = '{4'h7, 4'b0001, 1'b0};
      bus.in_valid = 1'b0;
      bus.in_result = '0;
      bus.in_rd = '0;
      bus.in_regwrite = 1'b0;
      bus.in_flagwrite = 1'b0;
      bus.in_nzcv = '0;
      bus.in_cond = '0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst out_result", bus.out_result, 32'd0);
      chk("rst out_rd", 32'(bus.out_rd), 32'd0);
      chk("rst out_regwrite", 32'(bus.out_regwrite), 32'd0);
      chk("rst out_condfail", 32'(bus.out_condfail), 32'd0);
      chk("rst flags", 32'(bus.flags_nzcv), 32'd0);
      rst = 1'b0;
      // single beat straight out of reset, 1-cycle latency
      beat(32'h0000_00FF, 4'd3, 1'b1, 1'b0, 4'h0, 4'hE, 1'b1);
      tick();
      // flag chain: the EQ beat sees the preceding flag write
      beat(32'h11, 4'd1, 1'b0, 1'b1, 4'b0100, 4'hE, 1'b1);
      beat(32'h22, 4'd2, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1);
      tick();
      // failed NE: no register or flag write when conditional execution is on
      beat(32'h33, 4'd4, 1'b1, 1'b1, 4'b1000, 4'h1, 1'b0);
      tick();
      chk("req034 flags", 32'(bus.flags_nzcv), 32'(eff(1'b0) ? 4'b1000 : 4'b0100));
      for (int i = 0; i < 24; i++) begin
         beat(32'h100 + 32'(i), 4'(i), 1'b1, 1'b1, tbl[i].nz, 4'hE, 1'b1);
         beat(32'hA000 + 32'(i), 4'(i + 1), 1'b1, 1'b0, 4'h0, tbl[i].cond, tbl[i].pass);
         tick();
      end
      // backpressure: third beat held until space frees, order preserved
      bus.out_ready = 1'b0;
      beat(32'h1, 4'd5, 1'b1, 1'b0, 4'h0, 4'hE, 1'b1);
      beat(32'h2, 4'd6, 1'b1, 1'b0, 4'h0, 4'hE, 1'b1);
      drive(32'h3, 4'd7, 1'b1, 1'b0, 4'h0, 4'hE, 1'b1);
      tick();
      tick();
      chk("held in_ready", 32'(bus.in_ready), 32'd0);
      bus.out_ready = 1'b1;
      tick();
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      chk("drained", 32'(q.size()), 32'd0);
      // push and pop together at occupancy 1
      beat(32'h44, 4'd8, 1'b1, 1'b0, 4'h0, 4'hE, 1'b1);
      beat(32'h55, 4'd9, 1'b1, 1'b0, 4'h0, 4'hE, 1'b1);
      chk("occ1 out_valid", 32'(bus.out_valid), 32'd1);
      chk("occ1 in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      // asynchronous reset with two entries buffered
      bus.out_ready = 1'b0;
      beat(32'h66, 4'd10, 1'b1, 1'b1, 4'b1111, 4'hE, 1'b1);
      beat(32'h77, 4'd11, 1'b1, 1'b0, 4'h0, 4'hE, 1'b1);
      chk("full out_valid", 32'(bus.out_valid), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("async out_valid", 32'(bus.out_valid), 32'd0);
      chk("async in_ready", 32'(bus.in_ready), 32'd1);
      chk("async flags", 32'(bus.flags_nzcv), 32'd0);
      chk("async out_result", bus.out_result, 32'd0);
      q.delete();
      mflags = '0;
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      beat(32'h88, 4'd12, 1'b1, 1'b0, 4'h0, 4'hE, 1'b1);
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
